serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq.sv | 144 ++++++++++++++
 tb/tb_serial_add_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_seq.sv
// serial_add_seq
//   Bit-serial adder. An accepted start latches operands a and b, then one
//   result bit is produced per RUN cycle, LSB first, using two cascaded
//   half adders and a registered carry. After WIDTH RUN cycles the block
//   spends one cycle in DONE and returns to IDLE. The result {carry, sum}
//   equals a + b and is held until the next accepted start.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   begin an addition (accepted only in IDLE)
//   a, b     in   operands, WIDTH bits, sampled on an accepted start
//   ready    out  high in IDLE
//   busy     out  high in RUN
//   done     out  one-cycle pulse in DONE
//   sum      out  result bits, filled LSB first
//   carry    out  carry-out of the MSB, valid from DONE onward
//   bit_idx  out  index of the bit being computed (0 outside RUN)
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     ready,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         sum,
    output logic                     carry,
    output logic [$clog2(WIDTH)-1:0] bit_idx
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;

    // Returns {carry, sum} of a single half adder.
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    logic [1:0] ha1;
    logic [1:0] ha2;
    logic       sum_bit;
    logic       c_nxt;

    always_comb begin
        ha1     = half_add(a_q[bit_idx], b_q[bit_idx]);
        ha2     = half_add(ha1[0], c_q);
        sum_bit = ha2[0];
        // Both half-adder carries can never be high together, so OR suffices.
        c_nxt   = ha1[1] | ha2[1];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (bit_idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand latch, serial sum/carry and bit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum     <= '0;
            carry   <= 1'b0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= 1'b0;
                        sum     <= '0;
                        carry   <= 1'b0;
                        bit_idx <= '0;
                    end
                end
                RUN: begin
                    sum[bit_idx] <= sum_bit;
                    c_q          <= c_nxt;
                    if (bit_idx == LAST) begin
                        carry   <= c_nxt;
                        bit_idx <= '0;
                    end else begin
                        bit_idx <= bit_idx + IW'(1);
                    end
                end
                default: begin
                    bit_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Index 0: WIDTH=8 instance, index 1: WIDTH=3 instance.
    logic       st [2];
    logic [7:0] ai [2];
    logic [7:0] bi [2];

    logic       o_rdy [2];
    logic       o_bsy [2];
    logic       o_dn  [2];
    logic [7:0] o_sum [2];
    logic       o_c   [2];
    logic [7:0] o_bi  [2];

    logic       rdy8, bsy8, dn8, c8;
    logic [7:0] sum8;
    logic [2:0] bidx8;
    logic       rdy3, bsy3, dn3, c3;
    logic [2:0] sum3;
    logic [1:0] bidx3;
    logic [2:0] a3, b3;

    assign a3 = ai[1][2:0];
    assign b3 = bi[1][2:0];

    serial_add_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ai[0]), .b(bi[0]),
        .ready(rdy8), .busy(bsy8), .done(dn8), .sum(sum8), .carry(c8),
        .bit_idx(bidx8)
    );

    serial_add_seq #(.WIDTH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .a(a3), .b(b3),
        .ready(rdy3), .busy(bsy3), .done(dn3), .sum(sum3), .carry(c3),
        .bit_idx(bidx3)
    );

    assign o_rdy[0] = rdy8;  assign o_rdy[1] = rdy3;
    assign o_bsy[0] = bsy8;  assign o_bsy[1] = bsy3;
    assign o_dn[0]  = dn8;   assign o_dn[1]  = dn3;
    assign o_c[0]   = c8;    assign o_c[1]   = c3;
    assign o_sum[0] = sum8;
    assign o_sum[1] = {5'b0, sum3};
    assign o_bi[0]  = {5'b0, bidx8};
    assign o_bi[1]  = {6'b0, bidx3};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wid(input int i);
        return (i == 0) ? 8 : 3;
    endfunction

    // Behavioural model: phase = cycles since acceptance (0 = idle),
    // res = full (WIDTH+1)-bit result of the latest accepted addition.
    int phase [2];
    int res   [2];
    int nacc  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            phase[i] = 0;
            res[i]   = 0;
            nacc[i]  = 0;
            st[i]    = 1'b0;
            ai[i]    = 8'h00;
            bi[i]    = 8'h00;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                phase[i] <= 0;
                res[i]   <= 0;
            end else if (phase[i] != 0) begin
                phase[i] <= (phase[i] == wid(i) + 1) ? 0 : phase[i] + 1;
            end else if (st[i]) begin
                phase[i] <= 1;
                res[i]   <= (int'(ai[i]) & ((1 << wid(i)) - 1))
                          + (int'(bi[i]) & ((1 << wid(i)) - 1));
                nacc[i]  <= nacc[i] + 1;
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                int w, m, e_s, e_bi;
                logic e_r, e_b, e_d, e_c;
                w = wid(i);
                m = (1 << w) - 1;
                e_r = 1'b0; e_b = 1'b0; e_d = 1'b0;
                e_bi = 0;
                e_s = res[i] & m;
                e_c = ((res[i] >> w) & 1) != 0;
                if (phase[i] == 0) begin
                    e_r = 1'b1;
                end else if (phase[i] <= w) begin
                    e_b  = 1'b1;
                    e_bi = phase[i] - 1;
                    e_s  = res[i] & ((1 << (phase[i] - 1)) - 1);
                    e_c  = 1'b0;
                end else begin
                    e_d = 1'b1;
                end
                checks++;
                if (o_rdy[i] !== e_r || o_bsy[i] !== e_b || o_dn[i] !== e_d ||
                    int'(o_bi[i]) != e_bi || int'(o_sum[i]) != e_s || o_c[i] !== e_c) begin
                    failures++;
                    $display("FAIL model w=%0d cyc=%0d got rdy/bsy/dn=%b%b%b bit_idx=%0d sum=%0h carry=%b exp rdy/bsy/dn=%b%b%b bit_idx=%0d sum=%0h carry=%b",
                             w, cyc, o_rdy[i], o_bsy[i], o_dn[i], o_bi[i], o_sum[i], o_c[i],
                             e_r, e_b, e_d, e_bi, e_s, e_c);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Called at posedge+#2 with the WIDTH=8 DUT idle. Returns at posedge+#2
    // right after the DONE cycle, so a following call is back-to-back.
    task automatic go(input logic [7:0] a, input logic [7:0] b,
                      input int exp_sum, input int exp_c, input bit hold,
                      input string name, output int done_cyc);
        int n;
        bit got;
        st[0] = 1'b1; ai[0] = a; bi[0] = b;
        @(posedge clk); #2;
        if (hold) begin
            ai[0] = 8'h00; bi[0] = 8'h00;
        end else begin
            st[0] = 1'b0;
        end
        n = 0; got = 1'b0; done_cyc = -1;
        while (n < 20 && !got) begin
            @(negedge clk);
            n++;
            if (dn8) begin
                got = 1'b1;
                done_cyc = cyc;
                st[0] = 1'b0;
            end
        end
        st[0] = 1'b0;
        chk({name, " latency"}, got ? n : -1, 9);
        chk({name, " sum"}, int'(sum8), exp_sum);
        chk({name, " carry"}, int'(c8), exp_c);
        @(posedge clk); #2;
    endtask

    initial begin
        int d1, d2, dn_cnt, guard, base0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        chk("reset ready", int'(rdy8), 1);
        chk("reset busy/done", int'({bsy8, dn8}), 0);
        chk("reset sum/carry/idx", int'({sum8, c8, bidx8}), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        go(8'h00, 8'h00, 8'h00, 0, 1'b0, "zero", d1);
        go(8'hFF, 8'h01, 8'h00, 1, 1'b0, "ff+1", d1);
        go(8'hA5, 8'h5A, 8'hFF, 0, 1'b1, "hold", d1);

        dn_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (dn8) dn_cnt++;
        end
        chk("hold single done", dn_cnt, 0);
        @(posedge clk); #2;

        // Reset mid-operation at bit_idx 4
        st[0] = 1'b1; ai[0] = 8'h80; bi[0] = 8'h80;
        @(posedge clk); #2;
        st[0] = 1'b0;
        guard = 0;
        while (bidx8 != 3'd4 && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("abort reached idx4", int'(bidx8), 4);
        rst_n = 1'b0;
        #1;
        chk("abort ready", int'(rdy8), 1);
        chk("abort outputs", int'({bsy8, dn8, sum8, c8, bidx8}), 0);
        dn_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dn8) dn_cnt++;
        end
        chk("abort no done", dn_cnt, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        go(8'h80, 8'h80, 8'h00, 1, 1'b0, "80+80", d1);

        go(8'h12, 8'h34, 8'h46, 0, 1'b0, "b2b first", d1);
        go(8'h7F, 8'h01, 8'h80, 0, 1'b0, "b2b second", d2);
        chk("b2b done gap", d2 - d1, 10);

        // Randomized run on both widths
        base0 = nacc[0];
        guard = 0;
        while ((nacc[0] - base0 < 1000 || nacc[1] < 1000) && guard < 40000) begin
            for (int i = 0; i < 2; i++) begin
                st[i] = 1'($urandom_range(0, 1));
                ai[i] = 8'($urandom);
                bi[i] = 8'($urandom);
            end
            @(posedge clk); #2;
            guard++;
        end
        chk("random ops completed", (guard < 40000) ? 1 : 0, 1);
        st[0] = 1'b0; st[1] = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        chk("random idle at end", int'({rdy8, rdy3}), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
